// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, request record.
// No logic; no latency; no backpressure.
// Imported by dmem_responder and dmem_lane.
package dmem_responder_pkg;

    localparam logic [1:0] MEMOP_WORD = 2'b00;
    localparam logic [1:0] MEMOP_HALF = 2'b01;
    localparam logic [1:0] MEMOP_BYTE = 2'b10;
    localparam logic [1:0] MEMOP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_WAIT = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for one access: store merge into the old word, load extract + extend.
// Purely combinational, zero latency.
// No backpressure; misaligned low address bits are dropped, misalign flags them.
import dmem_responder_pkg::*;

module dmem_lane (
    input  logic [1:0]  op,
    input  logic        ext,
    input  logic [1:0]  addr,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] wr_word,
    output logic [31:0] rd_word,
    output logic        misalign
);

    logic [4:0]  byte_lo;
    logic [4:0]  half_lo;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_lo  = {addr, 3'b000};
    assign half_lo  = {addr[1], 4'b0000};
    assign byte_val = old_word[byte_lo +: 8];
    assign half_val = old_word[half_lo +: 16];

    always_comb begin
        wr_word  = old_word;
        rd_word  = old_word;
        misalign = 1'b0;
        case (op)
            MEMOP_BYTE: begin
                rd_word = {{24{ext & byte_val[7]}}, byte_val};
                wr_word[byte_lo +: 8] = wdata[7:0];
            end
            MEMOP_HALF: begin
                rd_word = {{16{ext & half_val[15]}}, half_val};
                wr_word[half_lo +: 16] = wdata[15:0];
                misalign = addr[0];
            end
            // word and the reserved code both act on the whole word
            default: begin
                wr_word  = wdata;
                misalign = |addr;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder (load/store slave); define DMEM_ALIGN_CHECK_EN for alignment errors.
// Latency: accept -> rsp_valid after LATENCY+1 edges; one access per LATENCY+2 cycles at best.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
import dmem_responder_pkg::*;

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    dmem_req_t   req_in, req_q, acc;
    logic        commit;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] idx;
    logic [31:0] old_word, wr_word, rd_word;
    logic        lane_misalign;
    logic        acc_err;

    assign req_in    = {req_we, req_op, req_ext, req_addr, req_wdata};
    assign req_ready = (state_q == DMEM_IDLE);
    assign rsp_valid = (state_q == DMEM_RESP);
    assign cnt_inc   = cnt_q + 4'd1;

    // With zero wait states the access happens on the accept edge, before the latch holds the request.
    assign acc      = (state_q == DMEM_IDLE) ? req_in : req_q;
    assign idx      = acc.addr[ADDR_W+1:2];
    assign old_word = mem[idx];

    logic unused_addr;
    assign unused_addr = ^acc.addr[31:ADDR_W+2];

    dmem_lane u_lane (
        .op       (acc.op),
        .ext      (acc.ext),
        .addr     (acc.addr[1:0]),
        .old_word (old_word),
        .wdata    (acc.wdata),
        .wr_word  (wr_word),
        .rd_word  (rd_word),
        .misalign (lane_misalign)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_err = lane_misalign | (acc.op == MEMOP_RSVD);
`else
    logic unused_misalign;
    assign unused_misalign = lane_misalign;
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                cnt_d = 4'd0;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = DMEM_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == LAT_C) begin
                    state_d = DMEM_RESP;
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == DMEM_IDLE && req_valid) begin
                req_q <= req_in;
            end
            if (commit) begin
                rsp_rdata <= (acc.we || acc_err) ? 32'd0 : rd_word;
                rsp_err   <= acc_err;
            end
        end
    end

    // Storage is never reset; a store lands only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (commit && acc.we && !acc_err) begin
            mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic        req_ext = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem_m [1024];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_ext   (req_ext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: word viewed as four little-endian bytes; size n bytes, low bits dropped to n-alignment.
    task automatic model(input logic we, input logic [1:0] op, input logic ext, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int w, n, off, base;
        logic [7:0] b [4];
        logic [31:0] val;
        w    = int'(addr[11:2]);
        off  = int'(addr[1:0]);
        n    = (op == 2'b10) ? 1 : (op == 2'b01) ? 2 : 4;
        base = off - (off % n);
        err  = CHK_EN && (((off % n) != 0) || (op == 2'b11));
        for (int i = 0; i < 4; i++) b[i] = mem_m[w][8*i +: 8];
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) b[base+k] = wdata[8*k +: 8];
                mem_m[w] = {b[3], b[2], b[1], b[0]};
            end else begin
                val = 32'd0;
                for (int k = 0; k < n; k++) val = val | (32'(b[base+k]) << (8*k));
                if (ext && n < 4 && b[base+n-1][7]) val = val | (32'hFFFF_FFFF << (8*n));
                rdata = val;
            end
        end
    endtask

    task automatic access(input logic we, input logic [1:0] op, input logic ext, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err);
        int cyc;
        logic [31:0] rd0;
        logic e0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_op = op; req_ext = ext; req_addr = addr; req_wdata = wdata;
        rsp_ready = (hold == 0);
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = 1'b0;
                req_we = 1'($urandom); req_op = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
        end while (!rsp_valid && cyc < 40);
        chk("latency", 32'(cyc), 32'(LAT + 1));
        rd0 = rsp_rdata;
        e0  = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b0;
            for (int h = 0; h < hold; h++) begin
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_ready", 32'(req_ready), 32'd0);
                chk("bp_rdata", rsp_rdata, rd0);
                chk("bp_err", 32'(rsp_err), 32'(e0));
                @(negedge clk);
            end
            rsp_ready = 1'b1;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        if (hold > 0) begin
            chk("bp_release_idle", 32'(req_ready), 32'd1);
            chk("bp_release_novalid", 32'(rsp_valid), 32'd0);
            req_valid = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] got);
        logic [31:0] exp_d, got_d;
        logic exp_e, got_e;
        model(we, op, ext, addr, wdata, exp_d, exp_e);
        access(we, op, ext, addr, wdata, hold, got_d, got_e);
        chk({tag, "_rdata"}, got_d, exp_d);
        chk({tag, "_err"}, 32'(got_e), 32'(exp_e));
        got = got_d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w40;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) run("preload", 1'b1, 2'b00, 1'b0, 32'(i * 4), $urandom, 0, got);

        // Reset during WAIT: the pending store must be dropped.
        run("rst_pre", 1'b1, 2'b00, 1'b0, 32'h14, 32'h1234_5678, 0, got);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 2'b00; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        rst = 1'b1;
        run("midrst_load", 1'b0, 2'b00, 1'b0, 32'h14, 32'd0, 0, got);
        chk("midrst_mem", got, 32'h1234_5678);

        run("sw10", 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, got);
        run("lw10", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 0, got);
        chk("lw10_lit", got, 32'hDEAD_BEEF);

        run("sw20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h80FF_7F01, 0, got);
        run("lb23", 1'b0, 2'b10, 1'b1, 32'h23, 32'd0, 0, got);
        chk("lb23_lit", got, 32'hFFFF_FF80);
        run("lbu23", 1'b0, 2'b10, 1'b0, 32'h23, 32'd0, 0, got);
        chk("lbu23_lit", got, 32'h0000_0080);
        run("lh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 0, got);
        chk("lh22_lit", got, 32'hFFFF_80FF);
        run("lhu20", 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 0, got);
        chk("lhu20_lit", got, 32'h0000_7F01);

        run("sw30", 1'b1, 2'b00, 1'b0, 32'h30, 32'h1122_3344, 0, got);
        run("sb31", 1'b1, 2'b10, 1'b0, 32'h31, 32'h0000_00AA, 0, got);
        run("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF, 0, got);
        run("lw30", 1'b0, 2'b00, 1'b0, 32'h30, 32'd0, 0, got);
        chk("lw30_lit", got, 32'hBEEF_AA44);

        run("bp_load", 1'b0, 2'b00, 1'b0, 32'h30, 32'd0, 5, got);
        chk("bp_load_lit", got, 32'hBEEF_AA44);

        w40 = mem_m[16];
        run("lw42", 1'b0, 2'b00, 1'b0, 32'h42, 32'd0, 0, got);
        chk("lw42_lit", got, CHK_EN ? 32'd0 : w40);
        run("sw42", 1'b1, 2'b00, 1'b0, 32'h42, 32'h5555_AAAA, 0, got);
        run("lw40", 1'b0, 2'b00, 1'b0, 32'h40, 32'd0, 0, got);

        run("sw1000", 1'b1, 2'b00, 1'b0, 32'h1000, 32'hA5A5_0F0F, 0, got);
        run("lw0000", 1'b0, 2'b00, 1'b0, 32'h0000, 32'd0, 0, got);
        chk("wrap_lit", got, 32'hA5A5_0F0F);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 7) << 12} | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            run("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 2), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
